add_sub_pipe: RTL and testbench
===============================

ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 The block SHALL have parameter N, default 32, operand/result width in bits per lane (N >= 4).
REQ-002 The block SHALL have parameter LANES, default 3, number of independent add/sub lanes (x, y, z of a CORDIC step).
REQ-003 The block SHALL have parameter STAGES, default 2, pipeline register depth (STAGES >= 1).
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: the input beat is valid.
REQ-007 Port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-008 Port x, input, LANES*N bits: signed first operands; lane k is bits [k*N +: N].
REQ-009 Port y, input, LANES*N bits: signed second operands, same packing.
REQ-010 Port a_s, input, LANES bits: per-lane op; 1 = x - y, 0 = x + y.
REQ-011 Port sat_en, input, 1 bit: 1 = saturate on overflow, 0 = two's-complement wrap; sampled per beat.
REQ-012 Port out_valid, output, 1 bit: the output beat is valid.
REQ-013 Port out_ready, input, 1 bit: downstream accepts the beat.
REQ-014 Port result, output, LANES*N bits: signed results, same packing.
REQ-015 Port ovf, output, LANES bits: per-lane signed-overflow flag for the presented beat.

Function
REQ-016 A beat SHALL transfer in when in_valid && in_ready, and out when out_valid && out_ready.
REQ-017 Per lane, the exact result SHALL be computed at N+1 bits (sign-extended operands); overflow = bit N != bit N-1.
REQ-018 On overflow with sat_en=1, the result SHALL be +(2^(N-1)-1) if the exact value is positive, else -2^(N-1); with sat_en=0, the low N bits SHALL be output.
REQ-019 ovf SHALL be set on overflow regardless of sat_en.
REQ-020 Arithmetic SHALL be done combinationally before the first register; stages 2..STAGES SHALL only carry data.
REQ-021 Latency SHALL be exactly STAGES cycles from input acceptance to out_valid when out_ready is held high.
REQ-022 Each stage SHALL hold a valid bit; a stage loads when it is empty or its downstream stage moves in the same cycle (elastic pipeline, no bubbles).
REQ-023 in_ready SHALL equal (stage-1 empty) OR (stage-1 advancing this cycle); throughput SHALL be one beat per cycle with out_ready=1.
REQ-024 With out_ready=0, the output beat, result and ovf SHALL stay stable until accepted; the pipeline SHALL fill to STAGES beats, then deassert in_ready.
REQ-025 Simultaneous accept-in and accept-out on a full pipeline SHALL neither lose nor duplicate a beat.
REQ-026 Beats SHALL exit in acceptance order; lanes SHALL never mix between beats.
REQ-027 Data registers of empty stages are don't-care; only valid bits matter.

Reset
REQ-028 On rst=1, all stage valid bits SHALL clear asynchronously: out_valid=0, result=0, ovf=0.
REQ-029 in_ready SHALL be 1 during and after reset (empty pipeline).
REQ-030 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear after release.

Structure
REQ-031 The saturation limits (MAX/MIN as a function of N) and the op encoding (ADD=0, SUB=1) SHALL live in the shared package cordic_pkg.
REQ-032 A combinational sub-module add_sub_lane (N-bit operands, a_s, sat_en -> result, ovf) SHALL be instantiated LANES times.

Verification (N=8, LANES=2, STAGES=2)
REQ-033 Reset to idle: rst pulsed mid-stream with 2 beats in flight -> out_valid=0 immediately; after release, no beats emerge; in_ready=1.
REQ-034 Basic ops, out_ready=1: lane0 100+20 add, lane1 100-20 sub -> 2 cycles later result 120 / 80, ovf=00.
REQ-035 Overflow: 100+100 with sat_en=1 -> 127, ovf=1; with sat_en=0 -> -56, ovf=1; -100-100 with sat_en=1 -> -128.
REQ-036 Back-pressure: stream beats 1..5 with out_ready=0 -> in_ready drops after 2 accepted; then out_ready=1 -> beats emerge 1..5 in order, one per cycle.
REQ-037 Full-throughput: random in_valid/out_ready, 1000 beats, compared against a reference model -> no loss, duplication, or reordering; output held stable while stalled.
REQ-038 Edge: -128 - 1 and 127 + 1, both sat modes -> saturated -128/127, or wrapped 127/-128, with ovf=1.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC add/sub datapath: op encoding and
// saturation limits expressed as functions of the lane width.
package cordic_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Limits are returned 64 bits wide; callers keep the low N bits.
  function automatic logic [63:0] sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/add_sub_lane.sv
// One combinational signed add/sub lane with overflow detection and
// optional saturation.
module add_sub_lane
  import cordic_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         a_s,
  input  logic         sat_en,
  output logic [N-1:0] result,
  output logic         ovf
);

  localparam logic [63:0] MAX64 = sat_max(N);
  localparam logic [63:0] MIN64 = sat_min(N);
  localparam logic [N-1:0] MAX_V = MAX64[N-1:0];
  localparam logic [N-1:0] MIN_V = MIN64[N-1:0];

  logic [N:0] x_ext;
  logic [N:0] y_ext;
  logic [N:0] exact;

  // Bit N of the exact sum is its true sign, so it picks the clamp direction.
  always_comb begin
    x_ext  = {x[N-1], x};
    y_ext  = {y[N-1], y};
    exact  = (op_e'(a_s) == OP_SUB) ? (x_ext - y_ext) : (x_ext + y_ext);
    ovf    = exact[N] ^ exact[N-1];
    result = exact[N-1:0];
    if (ovf && sat_en) begin
      result = exact[N] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/add_sub_pipe.sv
// Multi-lane signed add/sub with an elastic valid/ready pipeline; arithmetic
// sits before the first register, later stages only carry data.
module add_sub_pipe #(
  parameter int N      = 32,
  parameter int LANES  = 3,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] x,
  input  logic [LANES*N-1:0] y,
  input  logic [LANES-1:0]   a_s,
  input  logic               sat_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] result,
  output logic [LANES-1:0]   ovf
);

  logic [LANES*N-1:0] lane_res;
  logic [LANES-1:0]   lane_ovf;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    add_sub_lane #(.N(N)) u_lane (
      .x      (x[k*N +: N]),
      .y      (y[k*N +: N]),
      .a_s    (a_s[k]),
      .sat_en (sat_en),
      .result (lane_res[k*N +: N]),
      .ovf    (lane_ovf[k])
    );
  end

  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  valid_d;
  logic [STAGES-1:0]  adv;
  logic [LANES*N-1:0] res_q [STAGES];
  logic [LANES*N-1:0] res_d [STAGES];
  logic [LANES-1:0]   ovf_q [STAGES];
  logic [LANES-1:0]   ovf_d [STAGES];

  // A stage may load if the output drains or any stage from it onward is
  // empty; derived straight from the valid bits to avoid a combinational chain.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      adv[s] = out_ready;
      for (int j = s; j < STAGES; j++) begin
        if (!valid_q[j]) adv[s] = 1'b1;
      end
    end

    valid_d = valid_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    if (adv[0]) begin
      valid_d[0] = in_valid;
      res_d[0]   = lane_res;
      ovf_d[0]   = lane_ovf;
    end
    for (int s = 1; s < STAGES; s++) begin
      if (adv[s]) begin
        valid_d[s] = valid_q[s-1];
        res_d[s]   = res_q[s-1];
        ovf_d[s]   = ovf_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        res_q[s] <= '0;
        ovf_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < STAGES; s++) begin
        res_q[s] <= res_d[s];
        ovf_q[s] <= ovf_d[s];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe (N=8, LANES=2, STAGES=2) using an
// integer-arithmetic reference model and directed plus random streams.
module tb_add_sub_pipe;

  localparam int N      = 8;
  localparam int LANES  = 2;
  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic [1:0]  a_s = '0;
  logic        sat_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [1:0]  ovf;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [17:0] expq [$];
  logic        in_acc;
  logic        out_acc;
  logic        got_valid;
  logic [15:0] got_res;
  logic [1:0]  got_ovf;

  add_sub_pipe #(.N(N), .LANES(LANES), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .a_s       (a_s),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: exact integer result, then range check, clamp or wrap.
  function automatic logic [8:0] ref_lane(input logic [7:0] a, input logic [7:0] b,
                                          input logic sub, input logic sat);
    int ea, eb, exact;
    logic o;
    logic [7:0] r;
    ea    = $signed(a);
    eb    = $signed(b);
    exact = sub ? (ea - eb) : (ea + eb);
    o     = (exact > 127) || (exact < -128);
    if (o && sat) r = (exact > 0) ? 8'h7F : 8'h80;
    else          r = exact[7:0];
    return {o, r};
  endfunction

  function automatic logic [17:0] ref_beat(input logic [15:0] xv, input logic [15:0] yv,
                                           input logic [1:0] asv, input logic satv);
    logic [8:0] l0, l1;
    l0 = ref_lane(xv[7:0], yv[7:0], asv[0], satv);
    l1 = ref_lane(xv[15:8], yv[15:8], asv[1], satv);
    return {l1[8], l0[8], l1[7:0], l0[7:0]};
  endfunction

  task automatic cycle();
    #1;
    in_acc    = in_valid && in_ready;
    out_acc   = out_valid && out_ready;
    got_valid = out_valid;
    got_res   = result;
    got_ovf   = ovf;
    if (in_acc) expq.push_back(ref_beat(x, y, a_s, sat_en));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic one_beat(input logic [15:0] xv, input logic [15:0] yv, input logic [1:0] asv,
                          input logic satv, output logic [15:0] r, output logic [1:0] o,
                          output int lat);
    x = xv; y = yv; a_s = asv; sat_en = satv;
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    lat = -1; r = '0; o = '0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (out_acc) begin
        r = got_res; o = got_ovf; lat = i;
        break;
      end
    end
    expq.delete();
  endtask

  task automatic test_reset();
    #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    tests++; if (result !== 16'h0) begin fails++; $display("[TB] FAIL reset_result: got %0h expected 0", result); end
    tests++; if (ovf !== 2'b00) begin fails++; $display("[TB] FAIL reset_ovf: got %0b expected 00", ovf); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; sat_en = 1'b0; a_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      x = 16'(i + 1); y = 16'h0101;
      cycle();
    end
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL inflight_before_reset: got %0b expected 1", out_valid); end
    rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_out_valid: got %0b expected 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL async_reset_in_ready: got %0b expected 1", in_ready); end
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        cycle();
        if (got_valid) seen++;
      end
      tests++; if (seen != 0) begin fails++; $display("[TB] FAIL reset_discard: got %0d beats expected 0", seen); end
    end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_in_ready: got %0b expected 1", in_ready); end
    expq.delete();
  endtask

  task automatic test_basic();
    logic [15:0] r; logic [1:0] o; int lat;
    one_beat({8'd100, 8'd100}, {8'd20, 8'd20}, 2'b10, 1'b1, r, o, lat);
    tests++; if (r !== {8'd80, 8'd120}) begin fails++; $display("[TB] FAIL basic_result: got %0h expected %0h", r, {8'd80, 8'd120}); end
    tests++; if (o !== 2'b00) begin fails++; $display("[TB] FAIL basic_ovf: got %0b expected 00", o); end
    tests++; if (lat != STAGES) begin fails++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, STAGES); end
  endtask

  task automatic test_overflow();
    logic [15:0] r; logic [1:0] o; int lat;
    one_beat({8'h9C, 8'h64}, {8'h64, 8'h64}, 2'b10, 1'b1, r, o, lat);
    tests++; if (r !== {8'h80, 8'h7F}) begin fails++; $display("[TB] FAIL ovf_sat_result: got %0h expected 807f", r); end
    tests++; if (o !== 2'b11) begin fails++; $display("[TB] FAIL ovf_sat_flag: got %0b expected 11", o); end
    one_beat({8'h9C, 8'h64}, {8'h64, 8'h64}, 2'b10, 1'b0, r, o, lat);
    tests++; if (r !== {8'h38, 8'hC8}) begin fails++; $display("[TB] FAIL ovf_wrap_result: got %0h expected 38c8", r); end
    tests++; if (o !== 2'b11) begin fails++; $display("[TB] FAIL ovf_wrap_flag: got %0b expected 11", o); end
  endtask

  task automatic test_edge();
    logic [15:0] r; logic [1:0] o; int lat;
    one_beat({8'h7F, 8'h80}, {8'h01, 8'h01}, 2'b01, 1'b1, r, o, lat);
    tests++; if (r !== {8'h7F, 8'h80}) begin fails++; $display("[TB] FAIL edge_sat_result: got %0h expected 7f80", r); end
    tests++; if (o !== 2'b11) begin fails++; $display("[TB] FAIL edge_sat_flag: got %0b expected 11", o); end
    one_beat({8'h7F, 8'h80}, {8'h01, 8'h01}, 2'b01, 1'b0, r, o, lat);
    tests++; if (r !== {8'h80, 8'h7F}) begin fails++; $display("[TB] FAIL edge_wrap_result: got %0h expected 807f", r); end
    tests++; if (o !== 2'b11) begin fails++; $display("[TB] FAIL edge_wrap_flag: got %0b expected 11", o); end
  endtask

  task automatic test_back_to_back();
    int b = 1;
    int accepted = 0;
    int k = 1;
    int prevcyc = -1;
    logic [15:0] expv;
    expq.delete();
    out_ready = 1'b0; sat_en = 1'b0; a_s = 2'b00; y = 16'h0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (b <= 5);
      x = {8'(b + 10), 8'(b)};
      cycle();
      if (in_acc) begin accepted++; b++; end
    end
    tests++; if (accepted != STAGES) begin fails++; $display("[TB] FAIL bp_accepted: got %0d expected %0d", accepted, STAGES); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready: got %0b expected 0", in_ready); end
    tests++; if (result !== {8'd11, 8'd1}) begin fails++; $display("[TB] FAIL bp_held_result: got %0h expected 0b01", result); end
    out_ready = 1'b1;
    for (int i = 0; i < 30 && k <= 5; i++) begin
      in_valid = (b <= 5);
      x = {8'(b + 10), 8'(b)};
      cycle();
      if (in_acc) b++;
      if (out_acc) begin
        expv = {8'(k + 10), 8'(k)};
        tests++; if (got_res !== expv) begin fails++; $display("[TB] FAIL bp_order: got %0h expected %0h", got_res, expv); end
        if (k > 1) begin
          tests++; if (cyc != prevcyc + 1) begin fails++; $display("[TB] FAIL bp_throughput: got gap %0d expected 1", cyc - prevcyc); end
        end
        prevcyc = cyc;
        k++;
      end
    end
    in_valid = 1'b0;
    tests++; if (k != 6) begin fails++; $display("[TB] FAIL bp_drain: got %0d beats expected 5", k - 1); end
    expq.delete();
  endtask

  task automatic test_random();
    int sent = 0;
    int received = 0;
    logic prev_stalled = 1'b0;
    logic [15:0] prev_res = '0;
    logic [1:0]  prev_ovf = '0;
    logic [17:0] expb;
    expq.delete();
    for (int i = 0; i < 20000 && received < 1000; i++) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
      x         = 16'($urandom);
      y         = 16'($urandom);
      a_s       = 2'($urandom_range(0, 3));
      sat_en    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      cycle();
      if (in_acc) sent++;
      if (prev_stalled) begin
        tests++;
        if (got_valid !== 1'b1 || got_res !== prev_res || got_ovf !== prev_ovf) begin
          fails++;
          $display("[TB] FAIL rnd_stall_hold: got v=%0b %0h/%0b expected v=1 %0h/%0b", got_valid, got_res, got_ovf, prev_res, prev_ovf);
        end
      end
      if (out_acc) begin
        tests++;
        if (expq.size() == 0) begin
          fails++; $display("[TB] FAIL rnd_extra_beat: got %0h expected none", got_res);
        end else begin
          expb = expq.pop_front();
          if ({got_ovf, got_res} !== expb) begin
            fails++; $display("[TB] FAIL rnd_beat %0d: got %0h expected %0h", received, {got_ovf, got_res}, expb);
          end
        end
        received++;
      end
      prev_stalled = got_valid && !out_ready;
      prev_res = got_res;
      prev_ovf = got_ovf;
    end
    in_valid = 1'b0;
    tests++; if (received != 1000) begin fails++; $display("[TB] FAIL rnd_count: got %0d expected 1000", received); end
    tests++; if (expq.size() != 0) begin fails++; $display("[TB] FAIL rnd_leftover: got %0d expected 0", expq.size()); end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_edge();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
